// File: rtl/invaders_pkg.sv
// rtl/invaders_pkg.sv - grid geometry defaults, alive mask type and sequencer FSM states
package invaders_pkg;

  localparam int NUM_INVADERS_D      = 10;
  localparam int NUM_ROWS_D          = 3;
  localparam int OFFSET_D            = 100;
  localparam int INVADER_WIDTH_D     = 64;
  localparam int INVADER_HEIGHT_D    = 32;
  localparam int PROJECTILE_WIDTH_D  = 16;
  localparam int PROJECTILE_HEIGHT_D = 32;
  localparam int GRID_CELLS_D        = NUM_INVADERS_D * NUM_ROWS_D;

  localparam int COORD_W = 12;
  localparam int SUM_W   = 13;

  typedef logic [GRID_CELLS_D-1:0] alive_mask_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/aabb_overlap.sv
// rtl/aabb_overlap.sv - combinational inclusive box-overlap test on 13-bit coordinates
module aabb_overlap
  import invaders_pkg::*;
#(
  parameter int A_W = PROJECTILE_WIDTH_D,
  parameter int A_H = PROJECTILE_HEIGHT_D,
  parameter int B_W = INVADER_WIDTH_D,
  parameter int B_H = INVADER_HEIGHT_D
) (
  input  logic [SUM_W-1:0] a_x,
  input  logic [SUM_W-1:0] a_y,
  input  logic [SUM_W-1:0] b_x,
  input  logic [SUM_W-1:0] b_y,
  output logic             overlap
);

  logic x_ov;
  logic y_ov;

  // Touching edges count as overlap on both axes.
  always_comb begin
    x_ov    = (a_x <= b_x + SUM_W'(B_W)) && (a_x + SUM_W'(A_W) >= b_x);
    y_ov    = (a_y <= b_y + SUM_W'(B_H)) && (a_y + SUM_W'(A_H) >= b_y);
    overlap = x_ov && y_ov;
  end

endmodule

// File: rtl/collision_sequencer.sv
// rtl/collision_sequencer.sv - per-frame bullet/invader collision scan, one grid cell per clock
module collision_sequencer
  import invaders_pkg::*;
#(
  parameter int NUM_INVADERS      = NUM_INVADERS_D,
  parameter int NUM_ROWS          = NUM_ROWS_D,
  parameter int OFFSET            = OFFSET_D,
  parameter int INVADER_WIDTH     = INVADER_WIDTH_D,
  parameter int INVADER_HEIGHT    = INVADER_HEIGHT_D,
  parameter int PROJECTILE_WIDTH  = PROJECTILE_WIDTH_D,
  parameter int PROJECTILE_HEIGHT = PROJECTILE_HEIGHT_D
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          frame_start,
  input  logic                                          wave_reset,
  input  logic                                          bullet_active,
  input  logic [11:0]                                   projectile_xpos,
  input  logic [11:0]                                   projectile_ypos,
  input  logic [NUM_INVADERS*12-1:0]                    invader_x_positions,
  input  logic [9:0]                                    enemy_ypos,
  output logic [NUM_ROWS*NUM_INVADERS-1:0]              alive,
  output logic [$clog2(NUM_ROWS*NUM_INVADERS+1)-1:0]    alive_count,
  output logic                                          bullet_hit,
  output logic [$clog2(NUM_ROWS)-1:0]                   hit_row,
  output logic [$clog2(NUM_INVADERS)-1:0]               hit_col,
  output logic                                          scan_busy,
  output logic                                          scan_done,
  output logic                                          wave_cleared
);

  localparam int CELLS  = NUM_ROWS * NUM_INVADERS;
  localparam int CNT_W  = $clog2(CELLS + 1);
  localparam int ROW_W  = $clog2(NUM_ROWS);
  localparam int RCNT_W = $clog2(NUM_ROWS + 1);
  localparam int COL_W  = $clog2(NUM_INVADERS);
  localparam int IDX_W  = $clog2(CELLS);

  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(NUM_INVADERS - 1);
  localparam logic [RCNT_W-1:0] ROW_LIMIT = RCNT_W'(NUM_ROWS);

  seq_state_t state;
  seq_state_t state_next;

  logic [RCNT_W-1:0] row_q;
  logic [COL_W-1:0]  col_q;
  logic [11:0]       lat_px;
  logic [11:0]       lat_py;
  logic [9:0]        lat_ey;
  logic [11:0]       lat_ix [NUM_INVADERS];

  logic              in_grid;
  logic              overlap;
  logic              hit_now;
  logic [IDX_W-1:0]  cell_idx;
  logic [SUM_W-1:0]  row_y;
  logic [CELLS-1:0]  alive_next;
  logic [CNT_W-1:0]  count_next;

  // row_q runs one step past the last row: that flush cycle keeps a full
  // miss scan completing at a fixed CELLS+2 edges after frame_start.
  always_comb begin
    in_grid  = (row_q < ROW_LIMIT);
    cell_idx = IDX_W'(int'(row_q) * NUM_INVADERS + int'(col_q));
    row_y    = {3'b000, lat_ey} + SUM_W'(int'(row_q) * OFFSET);
  end

  aabb_overlap #(
    .A_W (PROJECTILE_WIDTH),
    .A_H (PROJECTILE_HEIGHT),
    .B_W (INVADER_WIDTH),
    .B_H (INVADER_HEIGHT)
  ) u_aabb (
    .a_x     ({1'b0, lat_px}),
    .a_y     ({1'b0, lat_py}),
    .b_x     ({1'b0, lat_ix[col_q]}),
    .b_y     (row_y),
    .overlap (overlap)
  );

  always_comb begin
    hit_now = (state == SCAN) && in_grid && alive[cell_idx] && overlap;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (frame_start) state_next = bullet_active ? LATCH : DONE;
      LATCH:   state_next = SCAN;
      SCAN:    if (hit_now || !in_grid) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (wave_reset) state_next = IDLE;
  end

  always_comb begin
    alive_next = alive;
    if (wave_reset) begin
      alive_next = '1;
    end else if (hit_now) begin
      alive_next[cell_idx] = 1'b0;
    end
    count_next = '0;
    for (int i = 0; i < CELLS; i++) begin
      count_next = count_next + CNT_W'(alive_next[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      alive        <= '1;
      alive_count  <= CNT_W'(CELLS);
      wave_cleared <= 1'b0;
      bullet_hit   <= 1'b0;
      scan_busy    <= 1'b0;
      scan_done    <= 1'b0;
      hit_row      <= '0;
      hit_col      <= '0;
      row_q        <= '0;
      col_q        <= '0;
      lat_px       <= '0;
      lat_py       <= '0;
      lat_ey       <= '0;
      for (int i = 0; i < NUM_INVADERS; i++) lat_ix[i] <= '0;
    end else begin
      state        <= state_next;
      alive        <= alive_next;
      alive_count  <= count_next;
      wave_cleared <= (alive_next == '0);
      bullet_hit   <= hit_now && !wave_reset;
      scan_done    <= (state_next == DONE);
      scan_busy    <= (state_next == LATCH) || (state_next == SCAN);
      if (hit_now && !wave_reset) begin
        hit_row <= ROW_W'(row_q);
        hit_col <= col_q;
      end
      if (state == LATCH) begin
        row_q  <= '0;
        col_q  <= '0;
        lat_px <= projectile_xpos;
        lat_py <= projectile_ypos;
        lat_ey <= enemy_ypos;
        for (int i = 0; i < NUM_INVADERS; i++) lat_ix[i] <= invader_x_positions[i*12 +: 12];
      end else if (state == SCAN) begin
        if (col_q == LAST_COL) begin
          col_q <= '0;
          row_q <= row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/collision_sequencer.md
Name: collision_sequencer

Overview:
- Per-frame controller that time-multiplexes one bounding-box comparator across the invader grid, one cell per clock.
- Owns the invader alive mask.
- Produces a single registered hit event per frame for the player-bullet logic and score logic.
- Sits between the invader formation movement logic and the player projectile controller. It is kicked once per frame at vblank.

Parameters:
- NUM_INVADERS, 10, invaders per row (columns)
- NUM_ROWS, 3, invader rows
- OFFSET, 100, vertical pixel pitch between rows
- INVADER_WIDTH, 64, invader box width in pixels
- INVADER_HEIGHT, 32, invader box height in pixels
- PROJECTILE_WIDTH, 16, bullet box width in pixels
- PROJECTILE_HEIGHT, 32, bullet box height in pixels

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse at start of vblank; starts a scan
- wave_reset  in  1  synchronous; restores all invaders alive, aborts any scan
- bullet_active  in  1  player bullet in flight
- projectile_xpos  in  12  bullet left edge
- projectile_ypos  in  12  bullet top edge
- invader_x_positions  in  NUM_INVADERS x 12  column left edges
- enemy_ypos  in  10  top edge of row 0
- alive  out  NUM_ROWS x NUM_INVADERS  1 = invader present
- alive_count  out  $clog2(NUM_ROWS*NUM_INVADERS+1)  number of set bits in alive
- bullet_hit  out  1  one-cycle pulse, bullet destroyed an invader
- hit_row  out  $clog2(NUM_ROWS)  row of last hit
- hit_col  out  $clog2(NUM_INVADERS)  column of last hit
- scan_busy  out  1  scan in progress
- scan_done  out  1  one-cycle pulse, scan finished
- wave_cleared  out  1  alive is all zero

Behaviour:
- Reset (rst low, asynchronous) values:
  - alive all ones, alive_count = NUM_ROWS*NUM_INVADERS
  - bullet_hit, scan_busy, scan_done, wave_cleared = 0
  - hit_row, hit_col = 0
  - FSM in IDLE
- FSM states: IDLE, LATCH, SCAN, DONE.
- IDLE:
  - frame_start with bullet_active=1 -> LATCH.
  - frame_start with bullet_active=0 -> DONE (no scan).
- LATCH (1 cycle):
  - Registers projectile_xpos/ypos, enemy_ypos and all invader_x_positions.
  - Sets row=0, col=0 and scan_busy=1.
  - -> SCAN.
- SCAN, one cell (row, col) per cycle, column-major within row: col increments, then wraps to 0 and row increments.
  - Hit condition: alive[row][col] AND x_overlap AND y_overlap, evaluated on latched values.
  - On hit:
    - alive[row][col] cleared next edge.
    - hit_row/hit_col loaded; bullet_hit pulses 1 cycle.
    - -> DONE.
  - At most one kill per scan (first hit in scan order wins).
  - Last cell (NUM_ROWS-1, NUM_INVADERS-1) without hit -> DONE.
- DONE: scan_done=1 for exactly 1 cycle, scan_busy=0, -> IDLE.
- Latency:
  - Hit at linear index k = row*NUM_INVADERS+col: bullet_hit asserted k+2 cycles after frame_start cycle.
  - Full miss scan: scan_done at NUM_ROWS*NUM_INVADERS+2 cycles.
  - The bullet_hit cycle coincides with scan_done.
- Geometry arithmetic, all sums 13-bit unsigned, no wrap:
  - row_y = enemy_ypos + row*OFFSET.
  - x_overlap = (px <= ix + INVADER_WIDTH) && (px + PROJECTILE_WIDTH >= ix).
  - y_overlap = (py <= row_y + INVADER_HEIGHT) && (py + PROJECTILE_HEIGHT >= row_y).
  - Edges are inclusive (touching counts).
- Dead cells are skipped logically, but still consume one cycle (fixed scan timing).
- frame_start while not IDLE: ignored.
- bullet_active dropping mid-scan: ignored (inputs latched).
- wave_reset:
  - Highest priority, any state.
  - Next edge: alive all ones, FSM -> IDLE, scan_busy=0.
  - No bullet_hit, no scan_done.
  - hit_row/hit_col hold.
- wave_cleared and alive_count are registered from the next-state alive mask; they update the same edge alive changes.
- Asynchronous reset mid-scan: immediate return to reset values.

Decomposition:
- Package invaders_pkg holds:
  - Geometry defaults: invader/projectile width/height, OFFSET, grid size.
  - Typedef for the alive mask.
  - FSM state enum.
- One natural sub-module: aabb_overlap, a combinational 13-bit inclusive box-overlap check, instantiated once.

Test Plan:
1. Reset release -> alive all ones, alive_count=30, wave_cleared=0, all pulses 0.
2. Hit cell (0,0):
   - Stimulus: enemy_ypos=50, x[0]=100, bullet (110,60) active, frame_start.
   - Response: bullet_hit exactly at frame_start+2; hit_row=0, hit_col=0; alive[0][0]=0; alive_count=29; scan_done same cycle.
3. Same bullet next frame -> cell (0,0) dead, no hit; scan_done at +32; alive unchanged.
4. Bullet (110,150), enemy_ypos=50 (row 1 at y=150), x all 100 -> hit (1,0) only, at +12; row 0 untouched.
5. Edge touch, x[3]=200, bullet x=264, y in row 0 -> hit (0,3); bullet x=265 -> no hit.
6. Kill all 30 via repeated frames -> wave_cleared=1 when alive_count hits 0; then wave_reset mid-scan -> alive all ones, no scan_done, scan_busy=0 next cycle.
